simon_key_schedule: RTL and testbench

Round-key generator for the SIMON 128/128 encryption path. Sits directly upstream of the round datapath sequenced by the cipher controller.
- On a start pulse, latches the 128-bit master key.
- Streams round keys k0..k(ROUNDS-1) to the datapath over a valid/ready handshake, one key per accepted transfer.
- Computes the key schedule on the fly, using two WORD_SIZE registers.

---
 rtl/simon_pkg.sv | 31 +++
 rtl/simon_key_schedule_if.sv | 28 ++
 rtl/simon_key_round.sv | 21 ++
 rtl/simon_key_schedule.sv | 99 +++++++++
 tb/tb_simon_key_schedule.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared constants, FSM state type and rotate helper for the SIMON 128/128 key schedule.
// The schedule is the m=2 variant only, so KEY_SIZE is always twice WORD_SIZE.
package simon_pkg;

  localparam int WORD_SIZE = 64;
  localparam int KEY_SIZE  = 2 * WORD_SIZE;
  localparam int ROUNDS    = 68;
  localparam int Z2_LEN    = 62;

  localparam logic [WORD_SIZE-1:0] C = ~WORD_SIZE'(3);

  // The leftmost character of the published z2 string is bit 61, so it is bit 0 of the sequence.
  localparam logic [Z2_LEN-1:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

  localparam logic [7:0] LAST_IDX = 8'(ROUNDS - 1);
  localparam logic [5:0] ZPTR_MAX = 6'(Z2_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [WORD_SIZE-1:0] ror(input logic [WORD_SIZE-1:0] x, input int r);
    return (x >> r) | (x << (WORD_SIZE - r));
  endfunction

  function automatic logic z2_bit(input logic [5:0] ptr);
    return Z2[ZPTR_MAX - ptr];
  endfunction

endpackage

// File: rtl/simon_key_schedule_if.sv
// Round-key stream from the key schedule to the round datapath.
// Valid/ready handshake: a key transfers on any cycle with rk_valid and rk_ready both high.
interface simon_key_schedule_if;
  import simon_pkg::*;

  logic [WORD_SIZE-1:0] rk_out;
  logic                 rk_valid;
  logic                 rk_ready;
  logic [7:0]           rk_index;
  logic                 rk_last;

  modport master (
    output rk_out,
    output rk_valid,
    output rk_index,
    output rk_last,
    input  rk_ready
  );

  modport slave (
    input  rk_out,
    input  rk_valid,
    input  rk_index,
    input  rk_last,
    output rk_ready
  );

endinterface

// File: rtl/simon_key_round.sv
// One step of the m=2 SIMON key recurrence: k(i+2) from k(i), k(i+1) and the current z2 bit.
// Purely combinational so the same block can serve a future decryption key path.
module simon_key_round
  import simon_pkg::*;
(
  input  logic [WORD_SIZE-1:0] i_ka,
  input  logic [WORD_SIZE-1:0] i_kb,
  input  logic                 i_zbit,
  output logic [WORD_SIZE-1:0] o_knew
);

  logic [WORD_SIZE-1:0] w_rot3;
  logic [WORD_SIZE-1:0] w_tmp;
  logic [WORD_SIZE-1:0] w_zword;

  assign w_rot3  = ror(i_kb, 3);
  assign w_tmp   = w_rot3 ^ ror(w_rot3, 1);
  assign w_zword = {{(WORD_SIZE-1){1'b0}}, i_zbit};
  assign o_knew  = C ^ w_zword ^ i_ka ^ w_tmp;

endmodule

// File: rtl/simon_key_schedule.sv
// SIMON 128/128 round-key generator: latches the master key on start and streams
// k0..k(ROUNDS-1) over a valid/ready handshake, holding only the two most recent key words.
module simon_key_schedule
  import simon_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_SIZE-1:0] key_in,
  simon_key_schedule_if.master rk_if,
  output logic                busy,
  output logic                done
);

  state_t               r_state, w_state_next;
  logic [WORD_SIZE-1:0] r_ka, w_ka_next;
  logic [WORD_SIZE-1:0] r_kb, w_kb_next;
  logic [7:0]           r_index, w_index_next;
  logic [5:0]           r_zptr, w_zptr_next;
  logic                 r_done, w_done_next;
  logic [WORD_SIZE-1:0] w_knew;
  logic                 w_zbit;
  logic                 w_xfer;
  logic                 w_last;

  assign w_zbit = z2_bit(r_zptr);

  simon_key_round u_round (
    .i_ka   (r_ka),
    .i_kb   (r_kb),
    .i_zbit (w_zbit),
    .o_knew (w_knew)
  );

  assign w_xfer = (r_state == RUN) && rk_if.rk_ready;
  assign w_last = (r_index == LAST_IDX);

  always_comb begin
    w_state_next = r_state;
    w_ka_next    = r_ka;
    w_kb_next    = r_kb;
    w_index_next = r_index;
    w_zptr_next  = r_zptr;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_ka_next    = key_in[WORD_SIZE-1:0];
          w_kb_next    = key_in[KEY_SIZE-1:WORD_SIZE];
          w_index_next = 8'd0;
          w_zptr_next  = 6'd0;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_xfer) begin
          w_ka_next   = r_kb;
          w_kb_next   = w_knew;
          w_zptr_next = (r_zptr == ZPTR_MAX) ? 6'd0 : r_zptr + 6'd1;
          // Index returns to 0 after the final key so it never reads past ROUNDS-1.
          if (w_last) begin
            w_index_next = 8'd0;
            w_done_next  = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_index_next = r_index + 8'd1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ka    <= '0;
      r_kb    <= '0;
      r_index <= 8'd0;
      r_zptr  <= 6'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ka    <= w_ka_next;
      r_kb    <= w_kb_next;
      r_index <= w_index_next;
      r_zptr  <= w_zptr_next;
      r_done  <= w_done_next;
    end
  end

  assign rk_if.rk_out   = r_ka;
  assign rk_if.rk_valid = (r_state == RUN);
  assign rk_if.rk_index = r_index;
  assign rk_if.rk_last  = (r_state == RUN) && w_last;
  assign busy           = (r_state == RUN);
  assign done           = r_done;

endmodule

// File: tb/tb_simon_key_schedule.sv
// Self-checking bench for simon_key_schedule against a string-driven model of the SIMON key recurrence.
module tb_simon_key_schedule;

  localparam int NR = 68;
  localparam string Z2_STR = "10101111011100000011010010011000101000010001111110010110110011";

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;

  simon_key_schedule_if rk_if ();

  simon_key_schedule dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .key_in (key_in),
    .rk_if  (rk_if.master),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] m_keys [NR];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] rot_r(input logic [63:0] x, input int r);
    return (x >> r) | (x << (64 - r));
  endfunction

  // Reference schedule straight from the published recurrence.
  task automatic build_model(input logic [127:0] key);
    logic [63:0] t;
    logic [63:0] zb;
    m_keys[0] = key[63:0];
    m_keys[1] = key[127:64];
    for (int i = 0; i < NR - 2; i++) begin
      t  = rot_r(m_keys[i+1], 3);
      t  = t ^ rot_r(t, 1);
      zb = (Z2_STR[i % 62] == "1") ? 64'd1 : 64'd0;
      m_keys[i+2] = 64'hFFFF_FFFF_FFFF_FFFC ^ zb ^ m_keys[i] ^ t;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(rk_if.rk_valid), 64'd0);
    check({tag, "_last"},  64'(rk_if.rk_last),  64'd0);
    check({tag, "_busy"},  64'(busy),           64'd0);
    check({tag, "_index"}, 64'(rk_if.rk_index), 64'd0);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    start = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    check_idle(tag);
    check({tag, "_out"},  rk_if.rk_out, 64'd0);
    check({tag, "_done"}, 64'(done),    64'd0);
  endtask

  task automatic pulse_start(input logic [127:0] key);
    key_in = key;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Streams one key load; rand_ready adds random backpressure, stall/intrude/abort are index-triggered.
  task automatic run_keys(input string name, input logic [127:0] key, input bit rand_ready,
                          input int stall_at, input int stall_len,
                          input int intrude_at, input int abort_at);
    int idx;
    int stall_left;
    bit rdy;
    build_model(key);
    pulse_start(key);
    idx = 0;
    stall_left = stall_len;
    for (int cyc = 0; cyc < 1000 && idx < NR; cyc++) begin
      check({name, "_valid"}, 64'(rk_if.rk_valid), 64'd1);
      check({name, "_index"}, 64'(rk_if.rk_index), 64'(idx));
      check({name, "_key"},   rk_if.rk_out,        m_keys[idx]);
      check({name, "_last"},  64'(rk_if.rk_last),  64'(idx == NR - 1));
      check({name, "_busy"},  64'(busy),           64'd1);
      check({name, "_done"},  64'(done),           64'd0);
      if (idx == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle({name, "_abort"});
        check({name, "_abort_out"},  rk_if.rk_out, 64'd0);
        check({name, "_abort_done"}, 64'(done),    64'd0);
        tick();
        check({name, "_abort_done2"}, 64'(done), 64'd0);
        check({name, "_abort_busy2"}, 64'(busy), 64'd0);
        $display("run %s key=%032h aborted at index %0d", name, key, idx);
        return;
      end
      rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (idx == stall_at && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end
      rk_if.rk_ready = rdy;
      if (idx == intrude_at) begin
        start  = 1'b1;
        key_in = ~key;
      end
      tick();
      start = 1'b0;
      if (rdy) idx++;
    end
    check({name, "_complete"}, 64'(idx), 64'(NR));
    check({name, "_done_pulse"}, 64'(done), 64'd1);
    check_idle({name, "_end"});
    rk_if.rk_ready = 1'b1;
    tick();
    check({name, "_done_once"}, 64'(done), 64'd0);
    check_idle({name, "_post"});
    $display("run %s key=%032h transfers=%0d", name, key, idx);
  endtask

  // Zero key against fixed vectors, independent of the model.
  task automatic zero_key_vectors();
    logic [63:0] exp_k [4];
    exp_k[0] = 64'd0;
    exp_k[1] = 64'd0;
    exp_k[2] = 64'hFFFF_FFFF_FFFF_FFFD;
    exp_k[3] = 64'h9FFF_FFFF_FFFF_FFFC;
    rk_if.rk_ready = 1'b1;
    pulse_start(128'd0);
    for (int i = 0; i < 4; i++) begin
      check("zero_key", rk_if.rk_out, exp_k[i]);
      check("zero_idx", 64'(rk_if.rk_index), 64'(i));
      $display("zero key k%0d = %016h", i, rk_if.rk_out);
      tick();
    end
    apply_reset("zero_rst");
  endtask

  initial begin
    logic [127:0] rk;
    reset = 1'b1;
    start = 1'b0;
    key_in = '0;
    rk_if.rk_ready = 1'b0;
    apply_reset("reset");

    zero_key_vectors();

    run_keys("std", 128'h0f0e0d0c0b0a0908_0706050403020100, 1'b0, -1, 0, -1, -1);
    run_keys("stall", 128'h0f0e0d0c0b0a0908_0706050403020100, 1'b0, 10, 5, -1, -1);
    run_keys("intrude", 128'h0f0e0d0c0b0a0908_0706050403020100, 1'b0, -1, 0, 20, -1);
    run_keys("last_start", {$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, 0, NR - 1, -1);
    run_keys("abort", 128'h0f0e0d0c0b0a0908_0706050403020100, 1'b0, -1, 0, -1, 30);
    run_keys("restart", 128'h0f0e0d0c0b0a0908_0706050403020100, 1'b0, -1, 0, -1, -1);

    for (int r = 0; r < 4; r++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      run_keys($sformatf("rand%0d", r), rk, 1'b1, -1, 0, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
